// File: rtl/pcie_tm_writer.sv
// Writer half of the PCIe shared-memory timing-model link: buffers retired cpu2tm tokens
// and writes each as a 4-word record (word 0 last, carrying a per-thread A/B toggle bit).
module pcie_tm_writer #(
   parameter int NTHREADS   = 64,
   parameter int TIDW       = 6,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cpu2tm_valid,
   input  logic                          cpu2tm_retired,
   input  logic [TIDW-1:0]               cpu2tm_tid,
   input  logic [30:0]                   cpu2tm_hdr,
   input  logic [95:0]                   cpu2tm_data,
   output logic                          pcie_we,
   output logic [10:0]                   pcie_waddr,
   output logic [31:0]                   pcie_wdata,
   input  logic                          pcie_wr_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic                          idle
);

   localparam int PTRW = $clog2(FIFO_DEPTH);
   localparam int CNTW = PTRW + 1;
   localparam logic [CNTW-1:0] FULL_CNT = CNTW'(FIFO_DEPTH);
   localparam logic [CNTW-1:0] ONE_CNT  = CNTW'(1);
   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_WRITE = 1'b1;

   logic [TIDW-1:0] tid_mem  [FIFO_DEPTH];
   logic [30:0]     hdr_mem  [FIFO_DEPTH];
   logic [95:0]     data_mem [FIFO_DEPTH];

   logic [PTRW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, head_ptr;
   logic [CNTW-1:0]     count_q, count_d;
   logic                overflow_q, overflow_d;
   logic [0:0]          state_q, state_d;
   logic [1:0]          beat_q, beat_d;
   logic [TIDW-1:0]     cur_tid_q, cur_tid_d;
   logic [30:0]         cur_hdr_q, cur_hdr_d;
   logic [95:0]         cur_data_q, cur_data_d;
   logic [NTHREADS-1:0] ab_q, ab_d;
   logic                we_q, we_d;
   logic [10:0]         waddr_q, waddr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                push_req, push_ok, pop, load;

   function automatic logic [31:0] data_word(input logic [95:0] d, input logic [1:0] b);
      case (b)
         2'd3:    return d[95:64];
         2'd2:    return d[63:32];
         default: return d[31:0];
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (push_ok) begin
         tid_mem[wr_ptr_q]  <= cpu2tm_tid;
         hdr_mem[wr_ptr_q]  <= cpu2tm_hdr;
         data_mem[wr_ptr_q] <= cpu2tm_data;
      end
   end

   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      cur_tid_d  = cur_tid_q;
      cur_hdr_d  = cur_hdr_q;
      cur_data_d = cur_data_q;
      ab_d       = ab_q;
      we_d       = we_q;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      pop        = 1'b0;
      load       = 1'b0;
      head_ptr   = rd_ptr_q;
      case (state_q)
         S_IDLE: begin
            if (count_q != '0) load = 1'b1;
         end
         default: begin
            if (we_q && !pcie_wr_busy) begin
               if (beat_q != 2'd0) begin
                  beat_d  = beat_q - 2'd1;
                  waddr_d = 11'({cur_tid_q, beat_d});
                  wdata_d = (beat_d == 2'd0) ? {~ab_q[cur_tid_q], cur_hdr_q}
                                             : data_word(cur_data_q, beat_d);
               end else begin
                  pop              = 1'b1;
                  ab_d[cur_tid_q]  = ~ab_q[cur_tid_q];
                  // The entry behind the one being popped can be chained with no bubble.
                  if (count_q > ONE_CNT) begin
                     load     = 1'b1;
                     head_ptr = rd_ptr_q + 1'b1;
                  end else begin
                     state_d = S_IDLE;
                     we_d    = 1'b0;
                  end
               end
            end
         end
      endcase
      if (load) begin
         state_d    = S_WRITE;
         beat_d     = 2'd3;
         cur_tid_d  = tid_mem[head_ptr];
         cur_hdr_d  = hdr_mem[head_ptr];
         cur_data_d = data_mem[head_ptr];
         we_d       = 1'b1;
         waddr_d    = 11'({tid_mem[head_ptr], 2'd3});
         wdata_d    = data_mem[head_ptr][95:64];
      end
   end

   always_comb begin
      push_req   = cpu2tm_valid & cpu2tm_retired;
      push_ok    = push_req & ((count_q != FULL_CNT) | pop);
      overflow_d = overflow_q | (push_req & ~push_ok);
      wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d    = count_q;
      if (push_ok && !pop)      count_d = count_q + ONE_CNT;
      else if (!push_ok && pop) count_d = count_q - ONE_CNT;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         state_q    <= S_IDLE;
         beat_q     <= 2'd0;
         cur_tid_q  <= '0;
         cur_hdr_q  <= '0;
         cur_data_q <= '0;
         ab_q       <= '0;
         we_q       <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         state_q    <= state_d;
         beat_q     <= beat_d;
         cur_tid_q  <= cur_tid_d;
         cur_hdr_q  <= cur_hdr_d;
         cur_data_q <= cur_data_d;
         ab_q       <= ab_d;
         we_q       <= we_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
      end
   end

   assign pcie_we    = we_q;
   assign pcie_waddr = waddr_q;
   assign pcie_wdata = wdata_q;
   assign fifo_count = count_q;
   assign overflow   = overflow_q;
   assign idle       = (count_q == '0) && (state_q == S_IDLE);

endmodule

// File: tb/tb_pcie_tm_writer.sv
// Directed bench for pcie_tm_writer: latency, A/B toggle, filtering, overflow,
// back-pressure and mid-record reset, checked with immediate assertions.
module tb_pcie_tm_writer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cpu2tm_valid = 1'b0;
   logic        cpu2tm_retired = 1'b0;
   logic [5:0]  cpu2tm_tid = '0;
   logic [30:0] cpu2tm_hdr = '0;
   logic [95:0] cpu2tm_data = '0;
   logic        pcie_we;
   logic [10:0] pcie_waddr;
   logic [31:0] pcie_wdata;
   logic        pcie_wr_busy = 1'b0;
   logic [3:0]  fifo_count;
   logic        overflow;
   logic        idle;

   int n_cmp = 0;
   int n_err = 0;
   int n_writes = 0;

   pcie_tm_writer #(.NTHREADS(64), .TIDW(6), .FIFO_DEPTH(8)) dut (
      .clk(clk), .rst(rst),
      .cpu2tm_valid(cpu2tm_valid), .cpu2tm_retired(cpu2tm_retired),
      .cpu2tm_tid(cpu2tm_tid), .cpu2tm_hdr(cpu2tm_hdr), .cpu2tm_data(cpu2tm_data),
      .pcie_we(pcie_we), .pcie_waddr(pcie_waddr), .pcie_wdata(pcie_wdata),
      .pcie_wr_busy(pcie_wr_busy), .fifo_count(fifo_count),
      .overflow(overflow), .idle(idle)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst && pcie_we && !pcie_wr_busy) n_writes++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic push(input logic [5:0] t, input logic [30:0] h, input logic [95:0] d);
      cpu2tm_valid = 1'b1;
      cpu2tm_retired = 1'b1;
      cpu2tm_tid = t;
      cpu2tm_hdr = h;
      cpu2tm_data = d;
      tick();
      cpu2tm_valid = 1'b0;
      cpu2tm_retired = 1'b0;
   endtask

   // Wait (bounded) for a beat about to be accepted, check it, then let the edge accept it.
   task automatic accept_beat(input string tag, input logic [10:0] a, input logic [31:0] d);
      bit found = 0;
      for (int i = 0; i < 20; i++) begin
         if (pcie_we && !pcie_wr_busy) begin
            found = 1;
            break;
         end
         tick();
      end
      check({tag, " present"}, 32'(found), 32'd1);
      if (found) begin
         $display("write %s addr=%03h data=%08h", tag, pcie_waddr, pcie_wdata);
         check({tag, " addr"}, 32'(pcie_waddr), 32'(a));
         check({tag, " data"}, pcie_wdata, d);
         tick();
      end
   endtask

   initial begin
      int w0;
      int e;
      logic [10:0] ea [4];
      logic [31:0] ed [4];

      // Reset state
      tick();
      tick();
      check("rst we", 32'(pcie_we), 32'd0);
      check("rst waddr", 32'(pcie_waddr), 32'd0);
      check("rst wdata", pcie_wdata, 32'd0);
      check("rst count", 32'(fifo_count), 32'd0);
      check("rst overflow", 32'(overflow), 32'd0);
      check("rst idle", 32'(idle), 32'd1);
      rst = 1'b1;
      tick();

      // Single token: exact latency, one beat per edge
      push(6'd5, 31'h1234, {32'hC, 32'hB, 32'hA});
      check("t1 count", 32'(fifo_count), 32'd1);
      check("t1 idle0", 32'(idle), 32'd0);
      tick();
      check("t1 b3 we", 32'(pcie_we), 32'd1);
      check("t1 b3 addr", 32'(pcie_waddr), 32'h017);
      check("t1 b3 data", pcie_wdata, 32'hC);
      tick();
      check("t1 b2 addr", 32'(pcie_waddr), 32'h016);
      check("t1 b2 data", pcie_wdata, 32'hB);
      tick();
      check("t1 b1 addr", 32'(pcie_waddr), 32'h015);
      check("t1 b1 data", pcie_wdata, 32'hA);
      tick();
      check("t1 b0 addr", 32'(pcie_waddr), 32'h014);
      check("t1 b0 data", pcie_wdata, 32'h80001234);
      tick();
      check("t1 idle", 32'(idle), 32'd1);
      check("t1 we off", 32'(pcie_we), 32'd0);
      check("t1 count0", 32'(fifo_count), 32'd0);

      // Two more tokens to tid 5: toggle goes 0 then 1
      push(6'd5, 31'h0AAA, {32'h3, 32'h2, 32'h1});
      push(6'd5, 31'h0BBB, {32'h6, 32'h5, 32'h4});
      accept_beat("t2a b3", 11'h017, 32'h3);
      accept_beat("t2a b2", 11'h016, 32'h2);
      accept_beat("t2a b1", 11'h015, 32'h1);
      accept_beat("t2a b0", 11'h014, 32'h00000AAA);
      check("t2 no bubble", 32'(pcie_we), 32'd1);
      accept_beat("t2b b3", 11'h017, 32'h6);
      accept_beat("t2b b2", 11'h016, 32'h5);
      accept_beat("t2b b1", 11'h015, 32'h4);
      accept_beat("t2b b0", 11'h014, 32'h80000BBB);
      check("t2 idle", 32'(idle), 32'd1);

      // Non-retired tokens are ignored
      w0 = n_writes;
      cpu2tm_valid = 1'b1;
      cpu2tm_retired = 1'b0;
      cpu2tm_tid = 6'd7;
      tick();
      tick();
      tick();
      cpu2tm_valid = 1'b0;
      check("t3 count", 32'(fifo_count), 32'd0);
      check("t3 idle", 32'(idle), 32'd1);
      tick();
      check("t3 we", 32'(pcie_we), 32'd0);
      check("t3 writes", 32'(n_writes - w0), 32'd0);

      // Overflow under held busy, then drain 8 records in order
      pcie_wr_busy = 1'b1;
      for (int i = 0; i < 8; i++)
         push(6'(i), 31'(32'h100 + i), {32'(i*16+3), 32'(i*16+2), 32'(i*16+1)});
      check("t4 count8", 32'(fifo_count), 32'd8);
      check("t4 no ovf", 32'(overflow), 32'd0);
      push(6'd8, 31'h108, {32'h83, 32'h82, 32'h81});
      check("t4 count full", 32'(fifo_count), 32'd8);
      check("t4 overflow", 32'(overflow), 32'd1);
      check("t4 held we", 32'(pcie_we), 32'd1);
      check("t4 held addr", 32'(pcie_waddr), 32'h003);
      check("t4 held data", pcie_wdata, 32'h3);
      w0 = n_writes;
      pcie_wr_busy = 1'b0;
      for (int i = 0; i < 8; i++) begin
         accept_beat("t4 b3", 11'(4*i+3), 32'(i*16+3));
         accept_beat("t4 b2", 11'(4*i+2), 32'(i*16+2));
         accept_beat("t4 b1", 11'(4*i+1), 32'(i*16+1));
         accept_beat("t4 b0", 11'(4*i), (i == 5) ? 32'h00000105 : 32'(32'h80000100 + i));
      end
      tick();
      tick();
      check("t4 writes", 32'(n_writes - w0), 32'd32);
      check("t4 idle", 32'(idle), 32'd1);
      check("t4 ovf sticky", 32'(overflow), 32'd1);

      // Busy toggling every other cycle during a record
      ea = '{11'h027, 11'h026, 11'h025, 11'h024};
      ed = '{32'h93, 32'h92, 32'h91, 32'h80000055};
      w0 = n_writes;
      push(6'd9, 31'h55, {32'h93, 32'h92, 32'h91});
      e = 0;
      for (int c = 0; c < 40 && e < 4; c++) begin
         bit acc;
         if (pcie_we) begin
            check("t5 addr", 32'(pcie_waddr), 32'(ea[e]));
            check("t5 data", pcie_wdata, ed[e]);
         end
         pcie_wr_busy = c[0];
         acc = pcie_we && !pcie_wr_busy;
         tick();
         if (acc) e++;
      end
      pcie_wr_busy = 1'b0;
      check("t5 beats", 32'(e), 32'd4);
      tick();
      check("t5 writes", 32'(n_writes - w0), 32'd4);
      check("t5 idle", 32'(idle), 32'd1);

      // Reset mid-record, then the same thread restarts with bit31=1
      push(6'd3, 31'h77, {32'h33, 32'h32, 32'h31});
      accept_beat("t6 b3", 11'h00F, 32'h33);
      accept_beat("t6 b2", 11'h00E, 32'h32);
      rst = 1'b0;
      #1;
      check("t6 we", 32'(pcie_we), 32'd0);
      check("t6 waddr", 32'(pcie_waddr), 32'd0);
      check("t6 wdata", pcie_wdata, 32'd0);
      check("t6 count", 32'(fifo_count), 32'd0);
      check("t6 overflow", 32'(overflow), 32'd0);
      check("t6 idle", 32'(idle), 32'd1);
      rst = 1'b1;
      tick();
      push(6'd3, 31'h78, {32'h43, 32'h42, 32'h41});
      accept_beat("t6r b3", 11'h00F, 32'h43);
      accept_beat("t6r b2", 11'h00E, 32'h42);
      accept_beat("t6r b1", 11'h00D, 32'h41);
      accept_beat("t6r b0", 11'h00C, 32'h80000078);
      check("t6r idle", 32'(idle), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pcie_tm_writer.md
# pcie_tm_writer

Writer half of the PCIe shared-memory link between the processor model and the host timing model. Accepts retired `cpu2tm` tokens, buffers them in a small FIFO, and writes each as a 4-word record into the per-thread slot of the PCIe write memory. Each record carries a per-thread A/B toggle bit in word 0; the host detects new data by a change in that bit. Word 0 is always written last so the host never sees a torn record.

## Interface
Parameters:
- `NTHREADS`, 64: number of hardware threads; thread `t` owns write-memory words `4t .. 4t+3`. `4*NTHREADS` ≤ 2048.
- `TIDW`, 6: thread-ID width, $clog2(NTHREADS).
- `FIFO_DEPTH`, 8: token FIFO entries, power of two.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cpu2tm_valid`  in  1  token present this cycle.
- `cpu2tm_retired`  in  1  token's instruction retired; non-retired tokens are ignored because they replay.
- `cpu2tm_tid`  in  TIDW  thread of the token.
- `cpu2tm_hdr`  in  31  header payload, word 0 bits 30:0.
- `cpu2tm_data`  in  96  payload; word 1 = [31:0], word 2 = [63:32], word 3 = [95:64].
- `pcie_we`  out  1  write strobe.
- `pcie_waddr`  out  11  write word address.
- `pcie_wdata`  out  32  write data.
- `pcie_wr_busy`  in  1  memory cannot accept a write this cycle.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  occupied entries.
- `overflow`  out  1  sticky: a retired token was dropped.
- `idle`  out  1  FIFO empty and no record in flight.

## Operation
- Push: `cpu2tm_valid & cpu2tm_retired` stores {tid, hdr, data}. The push is accepted if `fifo_count < FIFO_DEPTH`, or if a pop happens in the same cycle. Otherwise the token is dropped and `overflow` is set. `overflow` stays set until reset.
- `ABstore[NTHREADS-1:0]`: per-thread toggle bits, reset 0.
- FSM states:
  - IDLE: if the FIFO is non-empty, load its head into the output stage and go to WRITE with `beat=3`.
  - WRITE: present one beat. The beat is accepted on an edge where `pcie_we=1 & pcie_wr_busy=0`.
  - On acceptance with `beat>0`: decrement `beat`.
  - On acceptance with `beat=0`: flip `ABstore[tid]` and pop the FIFO. If the FIFO still holds an entry (not counting the one just popped), load it and stay in WRITE with `beat=3`. Otherwise go to IDLE.
- Beat order is 3, 2, 1, 0. Address is `{tid, beat[1:0]}`, zero-extended to 11 bits.
- Data per beat:
  - Beats 3..1: the corresponding `cpu2tm_data` word.
  - Beat 0: `{~ABstore[tid], hdr}`. Bit 31 is the new toggle value, so the first record per thread carries bit31=1.
- Back-pressure: while `pcie_wr_busy=1`, `pcie_we`, `pcie_waddr` and `pcie_wdata` hold their values.
- Records for the same thread are written in push order.

## Timing
- Reset values: `pcie_we=0`, `pcie_waddr=0`, `pcie_wdata=0`, `fifo_count=0`, `overflow=0`, `idle=1`, all `ABstore=0`, FSM in IDLE.
- `pcie_we`, `pcie_waddr` and `pcie_wdata` are registered.
- Latency: for a token pushed at edge E0 into an empty, idle block, beat 3 is visible after E1. With no busy, beats are accepted at E2, E3, E4 and E5. The pop and the AB flip take effect at E5.
- Throughput: sustained rate is 4 cycles per record, with no bubble between records.
- Busy: each busy cycle adds one cycle. Busy asserted at an edge is not an acceptance.
- FIFO pointers wrap modulo `FIFO_DEPTH`. `fifo_count` is updated on the same edge as the push or pop. A simultaneous push and pop leaves `fifo_count` unchanged.
- Reset mid-record: the block clears immediately, and the partial record and FIFO contents are lost. Because `ABstore` returns to 0, the host reader must be reset together with this block.

## Test plan
- Single token, tid=5, hdr=0x1234, data={0xC,0xB,0xA}, no busy -> writes (0x017,0xC), (0x016,0xB), (0x015,0xA), (0x014,0x80001234) on four consecutive accept edges; `idle` returns to 1 at E5.
- Two more tokens to tid=5 -> word 0 bit31 is 0 and then 1; `ABstore[5]` alternates.
- `cpu2tm_valid=1`, `cpu2tm_retired=0` -> no push, `fifo_count` stays 0, no writes.
- Push 9 tokens on consecutive cycles with `pcie_wr_busy=1` held -> `fifo_count=8`, the 9th is dropped and `overflow=1`. Release busy -> exactly 8 records are written in order, 32 writes total.
- Toggle `pcie_wr_busy` every other cycle during a record -> outputs stay stable while busy, 4 accepts in order, no duplicate or skipped beat.
- Assert `rst=0` after beat 2 of a record -> all outputs return to reset values immediately; the next token to that tid writes bit31=1.
